// File: rtl/imem_responder.sv
// imem_responder: instruction-memory read responder with wait states, flush and loader port (parity via IMEM_PARITY_EN)
module imem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,
    output logic              rsp_err,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_par_flip
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;
    logic              rd_err;
    logic              accept;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    assign req_ready = ~reset & ~flush & ~ld_we & (state == IDLE | (state == RESP & rsp_ready));
    assign accept    = req_valid & req_ready;
    // zero wait states read straight from the request; otherwise from the latched address
    assign rd_addr   = (WAIT_STATES == 0) ? req_addr : addr_q;
    assign rd_word   = mem[rd_addr];
`ifdef IMEM_PARITY_EN
    logic par [2**ADDR_W];
    assign rd_err = (^rd_word) ^ par[rd_addr];
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
            par[ld_addr] <= (^ld_data) ^ ld_par_flip;
        end
    end
`else
    logic unused_flip;
    assign unused_flip = ld_par_flip;
    assign rd_err      = 1'b0;
    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
        end else if (flush && state != IDLE) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            addr_q <= req_addr;
            if (WAIT_STATES == 0) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= rd_word;
                rsp_err   <= rd_err;
            end else begin
                state     <= WAIT;
                cnt       <= CNT_INIT;
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
            end
        end else if (state == WAIT) begin
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= rd_word;
                rsp_err   <= rd_err;
            end
        end else if (state == RESP && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of imem_responder at 0, 1 and 3 wait states sharing one stimulus bus
module tb_imem_responder;
`ifdef IMEM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif
    localparam logic [31:0] M0 = 32'h11110000, M1 = 32'h22220001, M2 = 32'h33330002;
    localparam logic [31:0] M3 = 32'h00000007, M4 = 32'h12345678, M5 = 32'h00A00093;
    localparam logic [31:0] M7 = 32'h77777777, M8 = 32'h88888888;

    logic clk = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b0;
    logic ld_we = 1'b0, ld_par_flip = 1'b0;
    logic [8:0] req_addr = '0, ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic rdy [3];
    logic val [3];
    logic err [3];
    logic [31:0] dat [3];
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    imem_responder #(.WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy[0]), .flush(flush), .rsp_valid(val[0]), .rsp_data(dat[0]), .rsp_ready(rsp_ready),
        .rsp_err(err[0]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_par_flip(ld_par_flip));
    imem_responder #(.WAIT_STATES(1)) u_ws1 (.clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy[1]), .flush(flush), .rsp_valid(val[1]), .rsp_data(dat[1]), .rsp_ready(rsp_ready),
        .rsp_err(err[1]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_par_flip(ld_par_flip));
    imem_responder #(.WAIT_STATES(3)) u_ws3 (.clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy[2]), .flush(flush), .rsp_valid(val[2]), .rsp_data(dat[2]), .rsp_ready(rsp_ready),
        .rsp_err(err[2]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_par_flip(ld_par_flip));

    typedef struct {
        logic        rv;
        logic [8:0]  ra;
        logic        rr;
        logic        fl;
        logic        e_rdy;
        logic        e_val;
        logic [31:0] e_dat;
        logic        e_err;
    } vec_t;
    vec_t vecs [16];

    function automatic vec_t mk(logic rv, logic [8:0] ra, logic rr, logic fl, logic e_rdy, logic e_val,
                                logic [31:0] e_dat, logic e_err);
        mk = '{rv, ra, rr, fl, e_rdy, e_val, e_dat, e_err};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [8:0] a, logic [31:0] d, logic flip);
        ld_we = 1'b1; ld_addr = a; ld_data = d; ld_par_flip = flip;
        step();
        ld_we = 1'b0; ld_par_flip = 1'b0;
    endtask

    task automatic do_reset();
        req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0; reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        step(); step();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_valid%0d", d), 32'(val[d]), 32'd0);
            chk($sformatf("reset_data%0d", d), dat[d], 32'd0);
            chk($sformatf("reset_err%0d", d), 32'(err[d]), 32'd0);
            chk($sformatf("reset_ready%0d", d), 32'(rdy[d]), 32'd0);
        end
        reset = 1'b0;
        #1 chk("idle_ready", 32'(rdy[0]), 32'd1);
        load(0, M0, 0); load(1, M1, 0); load(2, M2, 0); load(3, M3, 1);
        load(4, M4, 0); load(5, M5, 0); load(7, M7, 0); load(8, M8, 0);

        // WAIT_STATES=1 basic read
        do_reset();
        req_valid = 1'b1; req_addr = 9'd5; rsp_ready = 1'b1;
        #1 chk("ws1_accept_ready", 32'(rdy[1]), 32'd1);
        step(); req_valid = 1'b0;
        chk("ws1_wait_valid", 32'(val[1]), 32'd0);
        step();
        chk("ws1_rsp_valid", 32'(val[1]), 32'd1);
        chk("ws1_rsp_data", dat[1], M5);
        step();
        chk("ws1_idle_valid", 32'(val[1]), 32'd0);

        // WAIT_STATES=0 table: back-to-back, backpressure, parity, flush override
        vecs[0]  = mk(1, 0, 1, 0, 1, 1, M0, 0);
        vecs[1]  = mk(1, 1, 1, 0, 1, 1, M1, 0);
        vecs[2]  = mk(1, 2, 1, 0, 1, 1, M2, 0);
        vecs[3]  = mk(0, 0, 1, 0, 1, 0, M2, 0);
        vecs[4]  = mk(1, 5, 0, 0, 1, 1, M5, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 1, M5, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 1, M5, 0);
        vecs[7]  = mk(1, 0, 0, 0, 0, 1, M5, 0);
        vecs[8]  = mk(1, 0, 1, 0, 1, 1, M0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 1, 0, M0, 0);
        vecs[10] = mk(1, 3, 1, 0, 1, 1, M3, PAR);
        vecs[11] = mk(0, 0, 1, 0, 1, 0, M3, 0);
        vecs[12] = mk(1, 1, 0, 0, 1, 1, M1, 0);
        vecs[13] = mk(1, 2, 1, 1, 0, 0, M1, 0);
        vecs[14] = mk(1, 2, 1, 0, 1, 1, M2, 0);
        vecs[15] = mk(0, 0, 1, 0, 1, 0, M2, 0);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            req_valid = vecs[i].rv; req_addr = vecs[i].ra; rsp_ready = vecs[i].rr; flush = vecs[i].fl;
            #1 chk($sformatf("vec%0d_ready", i), 32'(rdy[0]), 32'(vecs[i].e_rdy));
            step();
            chk($sformatf("vec%0d_valid", i), 32'(val[0]), 32'(vecs[i].e_val));
            chk($sformatf("vec%0d_data", i), dat[0], vecs[i].e_dat);
            chk($sformatf("vec%0d_err", i), 32'(err[0]), 32'(vecs[i].e_err));
        end
        flush = 1'b0;

        // flush mid-WAIT at WAIT_STATES=3, then a clean read of addr 8
        do_reset();
        req_valid = 1'b1; req_addr = 9'd7; rsp_ready = 1'b1;
        step(); req_valid = 1'b0;
        step();
        flush = 1'b1;
        step(); flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= val[2];
            step();
        end
        chk("flush_no_rsp", 32'(seen), 32'd0);
        req_valid = 1'b1; req_addr = 9'd8;
        step(); req_valid = 1'b0;
        n = 1;
        while (!val[2] && n < 10) begin
            step();
            n++;
        end
        chk("ws3_latency_edges", 32'(n), 32'd4);
        chk("ws3_rsp_data", dat[2], M8);
        step();
        chk("ws3_rsp_done", 32'(val[2]), 32'd0);

        // read/write collision on the capture edge at WAIT_STATES=1
        do_reset();
        req_valid = 1'b1; req_addr = 9'd4; rsp_ready = 1'b1;
        step(); req_valid = 1'b0;
        ld_we = 1'b1; ld_addr = 9'd4; ld_data = 32'hDEADBEEF;
        step(); ld_we = 1'b0;
        chk("collide_valid", 32'(val[1]), 32'd1);
        chk("collide_old_data", dat[1], M4);
        req_valid = 1'b1;
        #1 chk("reread_ready", 32'(rdy[1]), 32'd1);
        step(); req_valid = 1'b0;
        chk("reread_wait_valid", 32'(val[1]), 32'd0);
        step();
        chk("reread_new_data", dat[1], 32'hDEADBEEF);
        step();

        // reset mid-WAIT at WAIT_STATES=3
        req_valid = 1'b1; req_addr = 9'd8;
        step(); req_valid = 1'b0;
        step();
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("midwait_reset_valid", 32'(val[2]), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen |= val[2];
        end
        chk("midwait_no_late_rsp", 32'(seen), 32'd0);

        // parity at WAIT_STATES=1: flipped word, then a clean reload
        do_reset();
        req_valid = 1'b1; req_addr = 9'd3; rsp_ready = 1'b0;
        step(); req_valid = 1'b0;
        step();
        chk("par_flip_valid", 32'(val[1]), 32'd1);
        chk("par_flip_err", 32'(err[1]), 32'(PAR));
        rsp_ready = 1'b1;
        step();
        chk("par_err_clears", 32'(err[1]), 32'd0);
        load(3, M3, 0);
        req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step();
        chk("par_clean_valid", 32'(val[1]), 32'd1);
        chk("par_clean_err", 32'(err[1]), 32'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
